gpio_serial_loader: RTL and testbench
=====================================

# gpio_serial_loader

Sequencer for the user-project pad configuration chain. It holds one configuration word per user I/O pad and shifts the full image out over a serial clock/data/load interface into the daisy-chained per-pad control blocks. Those blocks drive the `mprj_io_*` mode, enable and drive-mode inputs of the pad ring. It sits in the management domain between the housekeeping register interface and the pad control chain.

## Interface
Parameters:
- `PADS`, default 38: number of pads in the chain; equals `MPRJ_IO_PADS`.
- `WIDTH`, default 13: configuration bits per pad.
- `CLKDIV`, default 2: core cycles per serial clock phase. Legal range is 1..15.
- `DEFAULT`, default 13'h0403: reset value of every stored word.

Ports (direction, width, meaning):
- `clock`, in, 1: core clock. One clock domain only.
- `reset`, in, 1: reset. Synchronous and active-high.
- `cfg_we`, in, 1: write strobe for a stored word.
- `cfg_addr`, in, 6: pad index for read and write.
- `cfg_wdata`, in, WIDTH: write data.
- `cfg_rdata`, out, WIDTH: stored word at `cfg_addr`. Combinational.
- `xfer_start`, in, 1: request a full chain transfer.
- `busy`, out, 1: a transfer is in progress.
- `done`, out, 1: one-cycle pulse when a transfer completes.
- `serial_clock`, out, 1: chain shift clock. The chain shifts on its rising edge.
- `serial_data_out`, out, 1: chain data.
- `serial_load`, out, 1: chain latch strobe. The chain latches shift contents into pad controls.

## Operation
- Storage is PADS×WIDTH flops, all reset to `DEFAULT`.
- Write rule: a word is written when `cfg_we` is high, `busy` is low and `cfg_addr < PADS`. Otherwise the write is dropped silently.
- Read rule: `cfg_rdata` returns 0 when `cfg_addr >= PADS`.
- States:
  - IDLE: if `xfer_start`, clear the bit counter and go to LOW.
  - LOW: drive the current bit and hold `serial_clock`=0 for CLKDIV cycles, then go to HIGH.
  - HIGH: hold `serial_clock`=1 for CLKDIV cycles. Then advance the bit counter: go to LOW if bits remain, else go to LOAD.
  - LOAD: hold `serial_load`=1 for CLKDIV cycles, then go to DONE.
  - DONE: assert `done` for one cycle, then go to IDLE.
- Bit order: pad PADS-1 first, MSB first, ending with pad 0 bit 0. The chain input is adjacent to pad 0, so the first bit shifted lands at pad PADS-1.
- Bit counter: counts 0..PADS×WIDTH-1 (493 at default). Pad index = counter / WIDTH, bit = counter % WIDTH. It is implemented as a pad counter plus a bit counter, with no divider.
- Phase counter: width 4 bits, reloaded on every phase entry.
- `busy` = state ≠ IDLE. It is low in the DONE cycle.
- `xfer_start` is ignored while `busy`. A start request arriving in the DONE cycle is also ignored.
- `serial_data_out` is 0 in IDLE, LOAD and DONE.
- Reset mid-transfer returns the FSM to IDLE and all storage to `DEFAULT`. The chain keeps partial shift contents but is never latched, because `serial_load` never asserts.

## Timing
- Reset values: `busy`=0, `done`=0, `serial_clock`=0, `serial_data_out`=0, `serial_load`=0.
- `xfer_start` is sampled high at edge k. `busy` and the first LOW phase begin at cycle k+1.
- Bit i LOW phase: cycles k+1+2·CLKDIV·i to k+CLKDIV+2·CLKDIV·i. Its HIGH phase follows immediately.
- `serial_data_out` is registered and stable for the whole LOW and HIGH phase of its bit. This gives CLKDIV cycles of setup and of hold around the rising edge.
- Busy duration: `busy` is high for 2·CLKDIV·PADS·WIDTH + CLKDIV cycles. At defaults this is 1978 cycles. `done` asserts in the following cycle.
- All outputs are registered, except `cfg_rdata`.

## Configuration
- Macro: `SERIAL_LOADER_AUTOSTART_EN`.
- Defined: a transfer starts automatically in the first cycle after `reset` deasserts, exactly as if `xfer_start` had been sampled high at that edge. This pushes `DEFAULT` to every pad without firmware involvement.
- Undefined: transfers start only on `xfer_start`. After reset the FSM idles.

## Test plan
- Reset then idle, CLKDIV=2: all outputs 0 and `cfg_rdata` returns 13'h0403 for addresses 0..37. Address 40 reads 0.
- Write pad 37=13'h1FFF and pad 0=13'h0001, then pulse `xfer_start`:
  - Chain model captures 494 bits, first 13 bits all 1 and last bit 1.
  - `busy` is high for exactly 1978 cycles, followed by one `done` pulse.
  - `serial_load` is high for 2 cycles immediately before `done`.
- `cfg_we` to pad 5 with 13'h0AAA while busy, then a second transfer: storage for pad 5 is unchanged and the second image is identical to the first.
- `xfer_start` held high for the whole transfer: exactly one transfer runs, then a new one begins the cycle after `done`. No back-to-back start occurs in the DONE cycle.
- `reset` asserted at cycle 500 of a transfer: the next cycle shows all outputs 0, `serial_load` never pulses, and storage reads `DEFAULT`.
- With `SERIAL_LOADER_AUTOSTART_EN` defined: `busy` rises the cycle after `reset` falls, and the captured image is 38 copies of 13'h0403.

Source files
------------

// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader
//
// Holds one configuration word per user I/O pad and shifts the full image
// into the daisy-chained per-pad control blocks over a serial
// clock/data/load interface. Bits leave pad PADS-1 first, MSB first, and
// the last bit is pad 0 bit 0. The first bit shifted travels furthest down
// the chain, so it ends up at pad PADS-1.
//
// Ports:
//   clock           core clock (single domain)
//   reset           synchronous active-high reset
//   cfg_we          write strobe for a stored word (dropped while busy)
//   cfg_addr        pad index for read and write
//   cfg_wdata       write data
//   cfg_rdata       stored word at cfg_addr, combinational, 0 when out of range
//   xfer_start      request a full chain transfer (ignored while busy)
//   busy            transfer in progress (LOW/HIGH/LOAD phases)
//   done            one-cycle pulse after the load strobe
//   serial_clock    chain shift clock, chain shifts on its rising edge
//   serial_data_out chain data, stable across the LOW and HIGH phase of a bit
//   serial_load     chain latch strobe
//
// Build option:
//   SERIAL_LOADER_AUTOSTART_EN  when defined, a transfer starts on its own in
//                               the first cycle after reset deasserts, which
//                               pushes DEFAULT to every pad.
module gpio_serial_loader #(
    parameter int              PADS    = 38,
    parameter int              WIDTH   = 13,
    parameter int              CLKDIV  = 2,
    parameter logic [WIDTH-1:0] DEFAULT = WIDTH'(13'h0403)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [5:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_wdata,
    output logic [WIDTH-1:0] cfg_rdata,
    input  logic             xfer_start,
    output logic             busy,
    output logic             done,
    output logic             serial_clock,
    output logic             serial_data_out,
    output logic             serial_load
);

    localparam int PAD_W = (PADS > 1) ? $clog2(PADS) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [PAD_W-1:0] PAD_LAST   = PAD_W'(PADS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WIDTH - 1);
    localparam logic [3:0]       PHASE_LAST = 4'(CLKDIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        LOAD,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [3:0]       phase_cnt, phase_next;
    logic [PAD_W-1:0] pad_cnt, pad_next;
    logic [BIT_W-1:0] bit_cnt, bit_next;
    logic             start;
    logic             addr_ok;
    logic             phase_end;

    logic [WIDTH-1:0] cfg_mem [PADS];

    assign addr_ok   = (32'(cfg_addr) < PADS);
    assign cfg_rdata = addr_ok ? cfg_mem[cfg_addr] : '0;

`ifdef SERIAL_LOADER_AUTOSTART_EN
    // Set throughout reset and cleared on the first free-running edge, so it
    // looks exactly like xfer_start sampled high at that edge.
    logic auto_pending;

    always_ff @(posedge clock) begin
        if (reset) begin
            auto_pending <= 1'b1;
        end else begin
            auto_pending <= 1'b0;
        end
    end

    assign start = xfer_start | auto_pending;
`else
    assign start = xfer_start;
`endif

    // Configuration storage. Writes are blocked during a transfer so the
    // image being shifted out cannot tear.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PADS; i++) begin
                cfg_mem[i] <= DEFAULT;
            end
        end else if (cfg_we && !busy && addr_ok) begin
            cfg_mem[cfg_addr] <= cfg_wdata;
        end
    end

    // The linear bit counter (0..PADS*WIDTH-1) is kept as two down-counters
    // holding the pad and bit currently on the wire. Count 0 corresponds to
    // pad PADS-1 bit WIDTH-1, so no divider is needed.
    always_comb begin
        state_next = state;
        phase_next = phase_cnt;
        pad_next   = pad_cnt;
        bit_next   = bit_cnt;
        phase_end  = (phase_cnt == 4'd0);

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOW;
                    phase_next = PHASE_LAST;
                    pad_next   = PAD_LAST;
                    bit_next   = BIT_LAST;
                end
            end
            LOW: begin
                if (phase_end) begin
                    state_next = HIGH;
                    phase_next = PHASE_LAST;
                end else begin
                    phase_next = phase_cnt - 4'd1;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    phase_next = PHASE_LAST;
                    if (bit_cnt != '0) begin
                        bit_next   = bit_cnt - 1'b1;
                        state_next = LOW;
                    end else if (pad_cnt != '0) begin
                        pad_next   = pad_cnt - 1'b1;
                        bit_next   = BIT_LAST;
                        state_next = LOW;
                    end else begin
                        state_next = LOAD;
                    end
                end else begin
                    phase_next = phase_cnt - 4'd1;
                end
            end
            LOAD: begin
                if (phase_end) begin
                    state_next = DONE;
                end else begin
                    phase_next = phase_cnt - 4'd1;
                end
            end
            DONE: begin
                // A start request here is deliberately not looked at.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            phase_cnt <= '0;
            pad_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_next;
            phase_cnt <= phase_next;
            pad_cnt   <= pad_next;
            bit_cnt   <= bit_next;
        end
    end

    // Outputs are decoded from the next state so that they are registered
    // yet line up with the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy            <= 1'b0;
            done            <= 1'b0;
            serial_clock    <= 1'b0;
            serial_data_out <= 1'b0;
            serial_load     <= 1'b0;
        end else begin
            busy         <= (state_next == LOW) || (state_next == HIGH) ||
                            (state_next == LOAD);
            done         <= (state_next == DONE);
            serial_clock <= (state_next == HIGH);
            serial_load  <= (state_next == LOAD);
            if ((state_next == LOW) || (state_next == HIGH)) begin
                serial_data_out <= cfg_mem[pad_next][bit_next];
            end else begin
                serial_data_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// tb_gpio_serial_loader
//
// Self-checking bench for gpio_serial_loader at default parameters. A model
// of the pad storage produces the expected chain image; the expected bits are
// queued when a transfer is requested and popped as the chain model sees each
// rising serial_clock edge. With SERIAL_LOADER_AUTOSTART_EN defined the bench
// checks the automatic post-reset transfer instead of the firmware sequence.
`timescale 1ns/1ps
module tb_gpio_serial_loader;

    localparam int          PADS   = 38;
    localparam int          WIDTH  = 13;
    localparam int          CLKDIV = 2;
    localparam int          BITS   = PADS * WIDTH;
    localparam int          BUSY_LEN = 2 * CLKDIV * BITS + CLKDIV;
    localparam logic [12:0] DEF    = 13'h0403;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_addr = 6'd0;
    logic [12:0] cfg_wdata = 13'd0;
    logic [12:0] cfg_rdata;
    logic        xfer_start = 1'b0;
    logic        busy;
    logic        done;
    logic        serial_clock;
    logic        serial_data_out;
    logic        serial_load;

    int test_count = 0;
    int fail_count = 0;

    logic [12:0]  model_mem [PADS];
    bit           exp_q [$];
    logic [511:0] exp_img;
    logic [511:0] cap_img;
    int           shift_count = 0;
    logic         prev_sclk = 1'b0;
    logic         load_seen = 1'b0;

    always #5 clock = ~clock;

    gpio_serial_loader #(
        .PADS    (PADS),
        .WIDTH   (WIDTH),
        .CLKDIV  (CLKDIV),
        .DEFAULT (DEF)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_wdata       (cfg_wdata),
        .cfg_rdata       (cfg_rdata),
        .xfer_start      (xfer_start),
        .busy            (busy),
        .done            (done),
        .serial_clock    (serial_clock),
        .serial_data_out (serial_data_out),
        .serial_load     (serial_load)
    );

    task automatic checkOutput(input string tag, input logic [511:0] got,
                               input logic [511:0] expv);
        test_count++;
        if (got !== expv) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expv);
        end
    endtask

    // Queue the image the model says should appear on the chain.
    task automatic push_image();
        exp_img = '0;
        for (int p = PADS - 1; p >= 0; p--) begin
            for (int b = WIDTH - 1; b >= 0; b--) begin
                exp_q.push_back(model_mem[p][b]);
                exp_img = {exp_img[510:0], model_mem[p][b]};
            end
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < PADS; p++) begin
            model_mem[p] = DEF;
        end
    endtask

    // Chain model: shift on each rising serial_clock, sampled mid-cycle.
    always @(negedge clock) begin
        if (serial_load === 1'b1) begin
            load_seen = 1'b1;
        end
        if (serial_clock === 1'b1 && prev_sclk === 1'b0) begin
            cap_img = {cap_img[510:0], serial_data_out};
            shift_count++;
            if (exp_q.size() == 0) begin
                checkOutput("sb_depth", 512'(exp_q.size()), 512'd1);
            end else begin
                checkOutput("chain_bit", 512'(serial_data_out), 512'(exp_q.pop_front()));
            end
        end
        prev_sclk = serial_clock;
    end

    task automatic applyStimulus(input logic [5:0] addr, input logic [12:0] data,
                                 input bit accepted);
        @(negedge clock);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        @(negedge clock);
        cfg_we = 1'b0;
        if (accepted && addr < PADS) begin
            model_mem[addr] = data;
        end
    endtask

    task automatic read_check(input string tag, input logic [5:0] addr,
                              input logic [12:0] expv);
        @(negedge clock);
        cfg_addr = addr;
        #1;
        checkOutput(tag, 512'(cfg_rdata), 512'(expv));
    endtask

    task automatic check_quiet(input string tag);
        checkOutput({tag, "_busy"}, 512'(busy), 512'd0);
        checkOutput({tag, "_done"}, 512'(done), 512'd0);
        checkOutput({tag, "_sclk"}, 512'(serial_clock), 512'd0);
        checkOutput({tag, "_sdo"}, 512'(serial_data_out), 512'd0);
        checkOutput({tag, "_load"}, 512'(serial_load), 512'd0);
    endtask

    // Watches one busy period from its first cycle to the done cycle. Optionally
    // attempts a write to pad 5 in the middle, which must be dropped.
    task automatic watch_busy(input string tag, input bit busy_write);
        int   busy_len = 0;
        int   load_len = 0;
        int   guard = 0;
        logic last_load = 1'b0;
        while (busy === 1'b1 && guard < 3000) begin
            busy_len++;
            guard++;
            if (serial_load === 1'b1) load_len++;
            last_load = serial_load;
            cfg_we = 1'b0;
            if (busy_write && busy_len == 100) begin
                cfg_we    = 1'b1;
                cfg_addr  = 6'd5;
                cfg_wdata = 13'h0AAA;
            end
            @(negedge clock);
        end
        cfg_we = 1'b0;
        checkOutput({tag, "_busy_len"}, 512'(busy_len), 512'(BUSY_LEN));
        checkOutput({tag, "_done"}, 512'(done), 512'd1);
        checkOutput({tag, "_load_len"}, 512'(load_len), 512'd2);
        checkOutput({tag, "_load_before_done"}, 512'(last_load), 512'd1);
    endtask

    task automatic run_transfer(input string tag, input bit busy_write);
        push_image();
        shift_count = 0;
        cap_img = '0;
        @(negedge clock);
        xfer_start = 1'b1;
        @(negedge clock);
        xfer_start = 1'b0;
        checkOutput({tag, "_busy_rise"}, 512'(busy), 512'd1);
        watch_busy(tag, busy_write);
        @(negedge clock);
        checkOutput({tag, "_done_width"}, 512'(done), 512'd0);
        checkOutput({tag, "_shifts"}, 512'(shift_count), 512'(BITS));
        checkOutput({tag, "_sb_left"}, 512'(exp_q.size()), 512'd0);
        checkOutput({tag, "_image"}, cap_img, exp_img);
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_quiet("reset");
        for (int a = 0; a < PADS; a++) begin
            read_check("reset_rdata", 6'(a), DEF);
        end
        read_check("rdata_out_of_range", 6'd40, 13'd0);

`ifdef SERIAL_LOADER_AUTOSTART_EN
        push_image();
        shift_count = 0;
        cap_img = '0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("auto_busy_rise", 512'(busy), 512'd1);
        watch_busy("auto", 1'b0);
        begin
            logic [493:0] rep;
            rep = {38{13'h0403}};
            checkOutput("auto_image", cap_img, 512'(rep));
        end
        checkOutput("auto_shifts", 512'(shift_count), 512'(BITS));
`else
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("idle_after_reset", 512'(busy), 512'd0);

        applyStimulus(6'd37, 13'h1FFF, 1'b1);
        applyStimulus(6'd0, 13'h0001, 1'b1);
        read_check("rdata_pad37", 6'd37, 13'h1FFF);
        read_check("rdata_pad0", 6'd0, 13'h0001);

        run_transfer("xfer1", 1'b0);
        checkOutput("xfer1_first13", 512'(cap_img[493:481]), 512'h1FFF);
        checkOutput("xfer1_last_bit", 512'(cap_img[0]), 512'd1);

        run_transfer("xfer2", 1'b1);
        read_check("busy_write_dropped", 6'd5, DEF);
        run_transfer("xfer3", 1'b0);

        // xfer_start held high: one transfer, then a restart only from IDLE.
        begin
            int guard = 0;
            push_image();
            push_image();
            shift_count = 0;
            @(negedge clock);
            xfer_start = 1'b1;
            @(negedge clock);
            checkOutput("hold_busy_rise", 512'(busy), 512'd1);
            watch_busy("hold", 1'b0);
            checkOutput("hold_done_busy", 512'(busy), 512'd0);
            @(negedge clock);
            checkOutput("hold_no_b2b_busy", 512'(busy), 512'd0);
            checkOutput("hold_no_b2b_done", 512'(done), 512'd0);
            @(negedge clock);
            checkOutput("hold_restart", 512'(busy), 512'd1);
            xfer_start = 1'b0;
            while (busy === 1'b1 && guard < 3000) begin
                guard++;
                @(negedge clock);
            end
            checkOutput("hold2_done", 512'(done), 512'd1);
            checkOutput("hold_shifts", 512'(shift_count), 512'(2 * BITS));
            checkOutput("hold_sb_left", 512'(exp_q.size()), 512'd0);
        end

        // Reset in the middle of a transfer.
        push_image();
        load_seen = 1'b0;
        @(negedge clock);
        xfer_start = 1'b1;
        @(negedge clock);
        xfer_start = 1'b0;
        repeat (499) @(negedge clock);
        checkOutput("mid_busy", 512'(busy), 512'd1);
        reset = 1'b1;
        @(negedge clock);
        check_quiet("mid_reset");
        exp_q.delete();
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        read_check("mid_rdata_pad37", 6'd37, DEF);
        read_check("mid_rdata_pad0", 6'd0, DEF);
        repeat (3) @(negedge clock);
        checkOutput("mid_idle", 512'(busy), 512'd0);
        checkOutput("mid_no_load", 512'(load_seen), 512'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
